// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: sequences PC redirect, pipeline flush and RET stack fetch after EX branch resolution.
// Optional feature: define BR_SEQ_STATS_EN to add saturating taken_cnt / ret_cnt outputs.
module branch_seq_ctrl #(
    parameter int PC_W      = 8,
    parameter int FLUSH_CYC = 2,
    parameter int MEM_TMO   = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    input  logic [2:0]      btype,
    input  logic            b_take,
    input  logic [PC_W-1:0] br_target,
    input  logic            mem_rd_ack,
    input  logic [PC_W-1:0] mem_rd_data,
    input  logic            err_clr,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_next,
    output logic            flush_o,
    output logic            stall_o,
    output logic            mem_rd_req,
    output logic            busy,
    output logic            ret_err
`ifdef BR_SEQ_STATS_EN
    ,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     ret_cnt
`endif
);

    localparam logic [2:0] BT_NONE    = 3'b000;
    localparam logic [2:0] BT_RET     = 3'b111;
    localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TMO);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RET_RD,
        S_FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic [PC_W-1:0] pc_next_q, pc_next_d;
    logic            pc_load_q, pc_load_d;
    logic            ret_err_q, ret_err_d;
    logic            timeout;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_next_d   = pc_next_q;
        pc_load_d   = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    if (btype == BT_RET) begin
                        state_d    = S_RET_RD;
                        wait_cnt_d = '0;
                    end else if (btype != BT_NONE && b_take) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = '0;
                        pc_next_d   = br_target;
                        pc_load_d   = 1'b1;
                    end
                end
            end
            S_RET_RD: begin
                // An ack arriving on the timeout edge still completes the fetch.
                if (mem_rd_ack) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                    pc_next_d   = mem_rd_data;
                    pc_load_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TMO_LIMIT) begin
                        timeout = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            ret_err_d = 1'b1;
        end else if (err_clr) begin
            ret_err_d = 1'b0;
        end else begin
            ret_err_d = ret_err_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            pc_next_q   <= '0;
            pc_load_q   <= 1'b0;
            ret_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pc_next_q   <= pc_next_d;
            pc_load_q   <= pc_load_d;
            ret_err_q   <= ret_err_d;
        end
    end

    // Status decodes straight from state, so reset drops mem_rd_req without waiting for a clock.
    assign pc_load    = pc_load_q;
    assign pc_next    = pc_next_q;
    assign flush_o    = (state_q == S_FLUSH);
    assign stall_o    = (state_q == S_RET_RD);
    assign mem_rd_req = (state_q == S_RET_RD);
    assign busy       = (state_q != S_IDLE);
    assign ret_err    = ret_err_q;

`ifdef BR_SEQ_STATS_EN
    logic [15:0] taken_cnt_q;
    logic [15:0] ret_cnt_q;
    logic        ret_done;

    assign ret_done = (state_q == S_RET_RD) && mem_rd_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else if (err_clr) begin
            taken_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            if (pc_load_q && taken_cnt_q != 16'hFFFF) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
            if (ret_done && ret_cnt_q != 16'hFFFF) begin
                ret_cnt_q <= ret_cnt_q + 16'd1;
            end
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign ret_cnt   = ret_cnt_q;
`endif

endmodule
